// File: rtl/bram_port_arbiter_if.sv
// Requester-side port bundle for bram_port_arbiter: one access request channel
// plus its read-return path.
interface bram_port_arbiter_if #(
    parameter int DATA_WIDTH     = 64,
    parameter int MEM_ADDR_WIDTH = 13
);
    localparam int NUMBYTES = DATA_WIDTH / 8;

    logic                      req;
    logic                      gnt;
    logic                      we;
    logic                      lock;
    logic [MEM_ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0]     wdata;
    logic [NUMBYTES-1:0]       be;
    logic                      rvalid;
    logic [DATA_WIDTH-1:0]     rdata;

    modport master (output req, we, lock, addr, wdata, be,
                    input  gnt, rvalid, rdata);
    modport slave  (input  req, we, lock, addr, wdata, be,
                    output gnt, rvalid, rdata);
endinterface

// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing BRAM port A between two requesters, with bounded
// lock-based burst ownership and read data steered back after READ_LATENCY cycles.
module bram_port_arbiter #(
    parameter int DATA_WIDTH     = 64,
    parameter int NUMBYTES       = DATA_WIDTH / 8,
    parameter int MEM_ADDR_WIDTH = 13,
    parameter int READ_LATENCY   = 1,
    parameter int MAX_HOLD       = 16
) (
    input  logic                      s_axi_aclk,
    input  logic                      s_axi_areset,
    bram_port_arbiter_if.slave        m0,
    bram_port_arbiter_if.slave        m1,
    output logic                      bram_clk_a,
    output logic                      bram_rst_a,
    output logic                      bram_en_a,
    output logic [NUMBYTES-1:0]       bram_we_a,
    output logic [MEM_ADDR_WIDTH-1:0] bram_addr_a,
    output logic [DATA_WIDTH-1:0]     bram_wrdata_a,
    input  logic [DATA_WIDTH-1:0]     bram_rddata_a
);
    localparam int CNT_W = $clog2(MAX_HOLD) + 1;

    typedef enum logic [1:0] {IDLE, HOLD0, HOLD1} state_t;

    state_t                  r_state, w_stateNext;
    logic                    r_last, w_lastNext;
    logic [CNT_W-1:0]        r_holdCnt, w_holdCntNext;
    logic [READ_LATENCY-1:0] r_pipeValid, r_pipeId;

    logic w_gnt0, w_gnt1, w_acc, w_sel, w_we, w_lock, w_ownerReq;

    // Grant is zero-cycle; reset forces every grant low.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (!s_axi_areset) begin
            case (r_state)
                IDLE: begin
                    if (m0.req && m1.req) begin
                        w_gnt0 = r_last;
                        w_gnt1 = ~r_last;
                    end else begin
                        w_gnt0 = m0.req;
                        w_gnt1 = m1.req;
                    end
                end
                HOLD0:   w_gnt0 = m0.req;
                HOLD1:   w_gnt1 = m1.req;
                default: ;
            endcase
        end
    end

    assign w_acc      = w_gnt0 | w_gnt1;
    assign w_sel      = w_gnt1;
    assign w_we       = w_sel ? m1.we   : m0.we;
    assign w_lock     = w_sel ? m1.lock : m0.lock;
    assign w_ownerReq = (r_state == HOLD1) ? m1.req : m0.req;

    always_comb begin
        w_stateNext   = r_state;
        w_lastNext    = r_last;
        w_holdCntNext = r_holdCnt;
        if (w_acc) w_lastNext = w_sel;
        case (r_state)
            IDLE: begin
                if (w_acc && w_lock) begin
                    w_stateNext   = w_sel ? HOLD1 : HOLD0;
                    w_holdCntNext = CNT_W'(1);
                end
            end
            HOLD0, HOLD1: begin
                // Owner requesting implies it is granted this cycle.
                if (w_ownerReq && w_lock && (r_holdCnt < CNT_W'(MAX_HOLD - 1))) begin
                    w_holdCntNext = r_holdCnt + CNT_W'(1);
                end else begin
                    w_stateNext   = IDLE;
                    w_holdCntNext = '0;
                end
            end
            default: begin
                w_stateNext   = IDLE;
                w_holdCntNext = '0;
            end
        endcase
    end

    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            r_state   <= IDLE;
            r_last    <= 1'b1;
            r_holdCnt <= '0;
        end else begin
            r_state   <= w_stateNext;
            r_last    <= w_lastNext;
            r_holdCnt <= w_holdCntNext;
        end
    end

    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            r_pipeValid <= '0;
            r_pipeId    <= '0;
        end else begin
            r_pipeValid[0] <= w_acc & ~w_we;
            r_pipeId[0]    <= w_sel;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_pipeValid[i] <= r_pipeValid[i-1];
                r_pipeId[i]    <= r_pipeId[i-1];
            end
        end
    end

    assign m0.gnt    = w_gnt0;
    assign m1.gnt    = w_gnt1;
    assign m0.rvalid = r_pipeValid[READ_LATENCY-1] & ~r_pipeId[READ_LATENCY-1];
    assign m1.rvalid = r_pipeValid[READ_LATENCY-1] &  r_pipeId[READ_LATENCY-1];
    assign m0.rdata  = bram_rddata_a;
    assign m1.rdata  = bram_rddata_a;

    assign bram_clk_a    = s_axi_aclk;
    assign bram_rst_a    = 1'b0;
    assign bram_en_a     = w_acc;
    assign bram_we_a     = (w_acc && w_we) ? (w_sel ? m1.be : m0.be) : '0;
    assign bram_addr_a   = w_sel ? m1.addr  : m0.addr;
    assign bram_wrdata_a = w_sel ? m1.wdata : m0.wdata;
endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed self-checking bench for bram_port_arbiter with a behavioural BRAM
// model of matching read latency.
module tb_bram_port_arbiter;
    localparam int DW = 64;
    localparam int AW = 13;
    localparam int NB = DW / 8;
    localparam int RL = 2;
    localparam int MH = 16;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   vecCount = 0;
    int   errCount = 0;

    logic          bramClk, bramRst, bramEn;
    logic [NB-1:0] bramWe;
    logic [AW-1:0] bramAddr;
    logic [DW-1:0] bramWrData, bramRdData;
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] rdPipe [RL];

    bram_port_arbiter_if #(.DATA_WIDTH(DW), .MEM_ADDR_WIDTH(AW)) m0if ();
    bram_port_arbiter_if #(.DATA_WIDTH(DW), .MEM_ADDR_WIDTH(AW)) m1if ();

    bram_port_arbiter #(
        .DATA_WIDTH(DW), .NUMBYTES(NB), .MEM_ADDR_WIDTH(AW),
        .READ_LATENCY(RL), .MAX_HOLD(MH)
    ) dut (
        .s_axi_aclk(clock), .s_axi_areset(reset),
        .m0(m0if), .m1(m1if),
        .bram_clk_a(bramClk), .bram_rst_a(bramRst), .bram_en_a(bramEn),
        .bram_we_a(bramWe), .bram_addr_a(bramAddr), .bram_wrdata_a(bramWrData),
        .bram_rddata_a(bramRdData)
    );

    always #5 clock = ~clock;

    assign bramRdData = rdPipe[RL-1];

    // BRAM model: read captured before the byte-masked write, then delayed RL-1 more stages.
    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = 64'hA5A5_0000_0000_0000 | 64'(i);
        for (int i = 0; i < RL; i++) rdPipe[i] = '0;
        forever begin
            @(posedge bramClk);
            for (int i = RL - 1; i > 0; i--) rdPipe[i] = rdPipe[i-1];
            if (bramEn) begin
                rdPipe[0] = mem[bramAddr];
                for (int b = 0; b < NB; b++)
                    if (bramWe[b]) mem[bramAddr][b*8 +: 8] = bramWrData[b*8 +: 8];
            end
        end
    end

    task automatic applyStimulus(input bit port, input logic req, input logic we,
                                 input logic lock, input logic [AW-1:0] addr,
                                 input logic [DW-1:0] wdata, input logic [NB-1:0] be);
        if (port == 1'b0) begin
            m0if.req = req; m0if.we = we; m0if.lock = lock;
            m0if.addr = addr; m0if.wdata = wdata; m0if.be = be;
        end else begin
            m1if.req = req; m1if.we = we; m1if.lock = lock;
            m1if.addr = addr; m1if.wdata = wdata; m1if.be = be;
        end
    endtask

    task automatic idleBoth();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic test_reset();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 13'h001, 64'h1, 8'hFF);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 13'h002, 64'h2, 8'hFF);
        @(negedge clock); #1;
        vecCount++; if (m0if.gnt !== 1'b0) begin errCount++; $display("[TB] FAIL rst_gnt0: got %b expected 0", m0if.gnt); end
        vecCount++; if (m1if.gnt !== 1'b0) begin errCount++; $display("[TB] FAIL rst_gnt1: got %b expected 0", m1if.gnt); end
        vecCount++; if (bramEn !== 1'b0) begin errCount++; $display("[TB] FAIL rst_en: got %b expected 0", bramEn); end
        vecCount++; if (bramWe !== 8'h00) begin errCount++; $display("[TB] FAIL rst_we: got %h expected 00", bramWe); end
        vecCount++; if ({m0if.rvalid, m1if.rvalid} !== 2'b00) begin errCount++; $display("[TB] FAIL rst_rvalid: got %b expected 00", {m0if.rvalid, m1if.rvalid}); end
        vecCount++; if (bramRst !== 1'b0) begin errCount++; $display("[TB] FAIL bram_rst: got %b expected 0", bramRst); end
        idleBoth();
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_write_read();
        @(negedge clock);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 13'h010, 64'h1122334455667788, 8'hFF);
        #1;
        vecCount++; if (m0if.gnt !== 1'b1) begin errCount++; $display("[TB] FAIL wr_gnt0: got %b expected 1", m0if.gnt); end
        vecCount++; if (bramEn !== 1'b1) begin errCount++; $display("[TB] FAIL wr_en: got %b expected 1", bramEn); end
        vecCount++; if (bramWe !== 8'hFF) begin errCount++; $display("[TB] FAIL wr_we: got %h expected ff", bramWe); end
        vecCount++; if (bramAddr !== 13'h010) begin errCount++; $display("[TB] FAIL wr_addr: got %h expected 010", bramAddr); end
        vecCount++; if (bramWrData !== 64'h1122334455667788) begin errCount++; $display("[TB] FAIL wr_data: got %h expected 1122334455667788", bramWrData); end
        @(negedge clock);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 13'h010, '0, 8'hFF);
        #1;
        vecCount++; if (m0if.gnt !== 1'b1) begin errCount++; $display("[TB] FAIL rd_gnt0: got %b expected 1", m0if.gnt); end
        vecCount++; if (bramWe !== 8'h00) begin errCount++; $display("[TB] FAIL rd_we: got %h expected 00", bramWe); end
        for (int c = 1; c <= RL + 1; c++) begin
            @(negedge clock);
            idleBoth();
            #1;
            vecCount++; if (m0if.rvalid !== (c == RL)) begin errCount++; $display("[TB] FAIL rd_rvalid0 c=%0d: got %b expected %b", c, m0if.rvalid, c == RL); end
            vecCount++; if (m1if.rvalid !== 1'b0) begin errCount++; $display("[TB] FAIL rd_rvalid1 c=%0d: got %b expected 0", c, m1if.rvalid); end
            if (c == RL) begin
                vecCount++; if (m0if.rdata !== 64'h1122334455667788) begin errCount++; $display("[TB] FAIL rd_data: got %h expected 1122334455667788", m0if.rdata); end
            end
        end
    endtask

    task automatic test_alternate();
        int j;
        logic e0, e1;
        logic [DW-1:0] expData;
        // A lone m1 write leaves last=1 so m0 wins the first tie.
        @(negedge clock);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 13'h100, 64'h0, 8'hFF);
        #1;
        vecCount++; if (m1if.gnt !== 1'b1) begin errCount++; $display("[TB] FAIL alt_pre_gnt1: got %b expected 1", m1if.gnt); end
        for (int k = 0; k <= 8 + RL; k++) begin
            @(negedge clock);
            if (k < 8) begin
                applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 13'(k & ~1), '0, 8'hFF);
                applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 13'(k | 1), '0, 8'hFF);
            end else begin
                idleBoth();
            end
            #1;
            if (k < 8) begin
                vecCount++; if (m0if.gnt !== (k % 2 == 0)) begin errCount++; $display("[TB] FAIL alt_gnt0 k=%0d: got %b expected %b", k, m0if.gnt, k % 2 == 0); end
                vecCount++; if (m1if.gnt !== (k % 2 == 1)) begin errCount++; $display("[TB] FAIL alt_gnt1 k=%0d: got %b expected %b", k, m1if.gnt, k % 2 == 1); end
                vecCount++; if (bramAddr !== 13'(k)) begin errCount++; $display("[TB] FAIL alt_addr k=%0d: got %h expected %h", k, bramAddr, 13'(k)); end
            end
            j = k - RL;
            e0 = (j >= 0) && (j < 8) && (j % 2 == 0);
            e1 = (j >= 0) && (j < 8) && (j % 2 == 1);
            vecCount++; if (m0if.rvalid !== e0) begin errCount++; $display("[TB] FAIL alt_rvalid0 k=%0d: got %b expected %b", k, m0if.rvalid, e0); end
            vecCount++; if (m1if.rvalid !== e1) begin errCount++; $display("[TB] FAIL alt_rvalid1 k=%0d: got %b expected %b", k, m1if.rvalid, e1); end
            if (e0 || e1) begin
                expData = 64'hA5A5_0000_0000_0000 | 64'(j);
                vecCount++; if (m0if.rdata !== expData) begin errCount++; $display("[TB] FAIL alt_rdata k=%0d: got %h expected %h", k, m0if.rdata, expData); end
            end
        end
    endtask

    task automatic test_lock_burst();
        // A lone m0 write leaves last=0 so m1 wins the first tie.
        @(negedge clock);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 13'h200, 64'h0, 8'hFF);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        #1;
        vecCount++; if (m0if.gnt !== 1'b1) begin errCount++; $display("[TB] FAIL lk_pre_gnt0: got %b expected 1", m0if.gnt); end
        for (int i = 1; i <= 5; i++) begin
            @(negedge clock);
            applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 13'h201, 64'h5, 8'hFF);
            applyStimulus(1'b1, 1'b1, 1'b1, (i < 4), 13'(32'h20 + i), 64'(i), 8'hFF);
            #1;
            vecCount++; if (m0if.gnt !== (i == 5)) begin errCount++; $display("[TB] FAIL lk_gnt0 i=%0d: got %b expected %b", i, m0if.gnt, i == 5); end
            vecCount++; if (m1if.gnt !== (i < 5)) begin errCount++; $display("[TB] FAIL lk_gnt1 i=%0d: got %b expected %b", i, m1if.gnt, i < 5); end
        end
        @(negedge clock);
        idleBoth();
    endtask

    task automatic test_max_hold();
        @(negedge clock);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 13'h3FF, 64'h0, 8'hFF);
        #1;
        vecCount++; if (m1if.gnt !== 1'b1) begin errCount++; $display("[TB] FAIL mh_pre_gnt1: got %b expected 1", m1if.gnt); end
        for (int i = 1; i <= MH + 1; i++) begin
            @(negedge clock);
            applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 13'(32'h300 + i), 64'(i), 8'hFF);
            applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 13'h3FF, 64'h0, 8'hFF);
            #1;
            vecCount++; if (m0if.gnt !== (i <= MH)) begin errCount++; $display("[TB] FAIL mh_gnt0 i=%0d: got %b expected %b", i, m0if.gnt, i <= MH); end
            vecCount++; if (m1if.gnt !== (i > MH)) begin errCount++; $display("[TB] FAIL mh_gnt1 i=%0d: got %b expected %b", i, m1if.gnt, i > MH); end
        end
        @(negedge clock);
        idleBoth();
    endtask

    task automatic test_partial_write();
        @(negedge clock);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 13'h030, 64'hFFFFFFFF_FFFFFFFF, 8'hFF);
        #1;
        vecCount++; if (m0if.gnt !== 1'b1) begin errCount++; $display("[TB] FAIL pw_fill_gnt0: got %b expected 1", m0if.gnt); end
        @(negedge clock);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 13'h030, 64'hAAAAAAAA_BBBBBBBB, 8'h0F);
        #1;
        vecCount++; if (bramWe !== 8'h0F) begin errCount++; $display("[TB] FAIL pw_we: got %h expected 0f", bramWe); end
        @(negedge clock);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 13'h030, '0, 8'hFF);
        #1;
        vecCount++; if (bramWe !== 8'h00) begin errCount++; $display("[TB] FAIL pw_rd_we: got %h expected 00", bramWe); end
        for (int c = 1; c <= RL; c++) begin
            @(negedge clock);
            idleBoth();
            #1;
            vecCount++; if (m0if.rvalid !== (c == RL)) begin errCount++; $display("[TB] FAIL pw_rvalid0 c=%0d: got %b expected %b", c, m0if.rvalid, c == RL); end
            if (c == RL) begin
                vecCount++; if (m0if.rdata !== 64'hFFFFFFFF_BBBBBBBB) begin errCount++; $display("[TB] FAIL pw_rdata: got %h expected ffffffffbbbbbbbb", m0if.rdata); end
            end
        end
    endtask

    task automatic test_reset_flush();
        @(negedge clock);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 13'h005, '0, 8'hFF);
        #1;
        vecCount++; if (m0if.gnt !== 1'b1) begin errCount++; $display("[TB] FAIL rf_gnt0: got %b expected 1", m0if.gnt); end
        @(negedge clock);
        idleBoth();
        reset = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            vecCount++; if ({m0if.rvalid, m1if.rvalid} !== 2'b00) begin errCount++; $display("[TB] FAIL rf_rvalid c=%0d: got %b expected 00", c, {m0if.rvalid, m1if.rvalid}); end
            @(negedge clock);
            if (c == 2) reset = 1'b0;
        end
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 13'h040, 64'h0, 8'hFF);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 13'h041, 64'h0, 8'hFF);
        #1;
        vecCount++; if (m0if.gnt !== 1'b1) begin errCount++; $display("[TB] FAIL rf_tie_gnt0: got %b expected 1", m0if.gnt); end
        vecCount++; if (m1if.gnt !== 1'b0) begin errCount++; $display("[TB] FAIL rf_tie_gnt1: got %b expected 0", m1if.gnt); end
        @(negedge clock);
        idleBoth();
    endtask

    initial begin
        idleBoth();
        test_reset();
        test_write_read();
        test_alternate();
        test_lock_burst();
        test_max_hold();
        test_partial_write();
        test_reset_flush();
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end
endmodule

// File: doc/bram_port_arbiter.md
Name: bram_port_arbiter

Overview:
Two-requester arbiter and sequencer sharing one single-ported BRAM (port A) between two memory-side masters, e.g. an AXI-to-memory bridge and a DMA/debug loader.
- Arbitration is round-robin with an optional bounded lock for back-to-back bursts.
- Read data is steered back to the requester that issued each read, after the fixed BRAM read latency.
- The block sits between the requesters and the bram_*_a pins of the BRAM macro.

Parameters:
DATA_WIDTH, 64, BRAM data width in bits
NUMBYTES, DATA_WIDTH/8, byte-enable width
MEM_ADDR_WIDTH, 13, BRAM word address width
READ_LATENCY, 1, cycles from accepted read to valid bram_rddata_a; legal values 1..4
MAX_HOLD, 16, maximum consecutive accepted accesses one requester may chain under lock; minimum 2

Ports:
s_axi_aclk  in  1  clock; also drives bram_clk_a
s_axi_areset  in  1  asynchronous active-high reset
m0_req  in  1  requester 0 access request
m0_gnt  out  1  access accepted this cycle when m0_req & m0_gnt
m0_we  in  1  1 = write, 0 = read
m0_lock  in  1  keep ownership after this access
m0_addr  in  MEM_ADDR_WIDTH  word address
m0_wdata  in  DATA_WIDTH  write data
m0_be  in  NUMBYTES  byte enables
m0_rvalid  out  1  read data valid, single-cycle pulse, no backpressure
m0_rdata  out  DATA_WIDTH  read data
m1_req, m1_gnt, m1_we, m1_lock, m1_addr, m1_wdata, m1_be, m1_rvalid, m1_rdata: same directions, widths and meanings as the m0_* ports, for requester 1
bram_clk_a  out  1  equals s_axi_aclk
bram_rst_a  out  1  constant 0
bram_en_a  out  1  BRAM enable
bram_we_a  out  NUMBYTES  byte write enables
bram_addr_a  out  MEM_ADDR_WIDTH  address
bram_wrdata_a  out  DATA_WIDTH  write data
bram_rddata_a  in  DATA_WIDTH  read data

Behaviour:
Clocking and reset:
- Single clock s_axi_aclk.
- s_axi_areset is asynchronous and active-high.
- Reset state: state=IDLE, last=1 (m0 wins the first tie), hold_cnt=0, read-return pipeline cleared.
- While reset is asserted: m*_gnt=0, m*_rvalid=0, bram_en_a=0, bram_we_a=0.
- Reset asserted mid-operation drops all in-flight reads; no rvalid is issued for them.

Grant (combinational from req, state and last; zero-cycle grant):
- IDLE:
  - Only one requester has req=1: it is granted.
  - Both have req=1: the one with index != last is granted.
- HOLD0 / HOLD1: only the owner can be granted; the other gnt=0 even if it requests.
- At most one gnt is high in any cycle.

BRAM drive (from the granted requester):
- On an accepted access: bram_en_a=1, bram_addr_a=addr, bram_wrdata_a=wdata.
- bram_we_a = be if we=1, else 0.
- No access accepted: bram_en_a=0, bram_we_a=0; address/data values are don't-care.

State transitions (registered, evaluated on each accepted access; last <= granted index on every accepted access):
- IDLE -> HOLDx: when requester x is accepted with lock=1; hold_cnt <= 1.
- HOLDx, owner accepted with lock=1 and hold_cnt < MAX_HOLD-1: stay in HOLDx; hold_cnt++.
- HOLDx -> IDLE, any one of:
  - owner accepted with lock=0;
  - owner accepted with hold_cnt == MAX_HOLD-1 (forced release, lock ignored);
  - owner req=0 in any cycle.
- Forced release lets the other requester win the next tie, via last.
- hold_cnt clears on entry to IDLE.

Read return:
- Shift pipeline of READ_LATENCY stages, each stage = {valid, id}.
- An accepted read pushes {1, granted index}; any other cycle pushes {0, x}.
- At pipeline output: m<id>_rvalid=1 for exactly one cycle.
- m0_rdata = m1_rdata = bram_rddata_a at all times; rvalid qualifies the data.
- Back-to-back reads from alternating requesters return in issue order, one per cycle, with no bubbles.
- Writes produce no response; write-then-read to the same address in consecutive cycles returns the new data (BRAM write-first or no-change collisions are avoided because the accesses are in different cycles).

Throughput:
- One access per cycle sustained.
- Under continuous contention with lock=0, grants alternate every cycle.

Test Plan:
- Reset, then m0 writes addr 0x010 data 0x1122334455667788 be=0xFF -> same cycle m0_gnt=1, bram_en_a=1, bram_we_a=0xFF; m0 then reads 0x010 -> m0_rvalid=1 exactly READ_LATENCY cycles later with m0_rdata=0x1122334455667788; m1_rvalid stays 0.
- m0_req and m1_req held high, lock=0, reads to addresses 0..7 -> grant order m0,m1,m0,m1,...; each rvalid pulse goes to the issuing requester in order.
- m1 locked burst of 4 writes (lock=1 on the first 3, 0 on the last) while m0_req=1 -> m0_gnt=0 for all 4 cycles; m0 granted in cycle 5.
- m0 holds lock=1 continuously with MAX_HOLD=16 while m1_req=1 -> m0 receives exactly 16 consecutive grants, then m1 is granted next.
- Partial write be=0x0F of 0xAAAAAAAA_BBBBBBBB over a location holding all-ones, then read back -> 0xFFFFFFFF_BBBBBBBB; bram_we_a=0x0F during the write and 0x00 during the read.
- Assert s_axi_areset one cycle after an accepted read -> no rvalid pulses; after release, a simultaneous m0/m1 request grants m0 first.
